// File: rtl/can_mcif_pkg.sv
// Shared constants and types for the CAN microcontroller interface.
// Write entries carry address, data and byte enables through the channel FIFO.
package can_mcif_pkg;

    localparam int CAN_ADDR_W = 6;
    localparam int CAN_DATA_W = 32;
    localparam int CAN_BE_W   = CAN_DATA_W / 8;

    localparam logic [63:0] CAN_WR_MASK_DEFAULT = 64'h0000_0001_FF03_FF2F;

    typedef struct packed {
        logic [CAN_ADDR_W-1:0] addr;
        logic [CAN_DATA_W-1:0] data;
        logic [CAN_BE_W-1:0]   be;
    } can_wr_entry_t;

    function automatic int can_entry_w(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

endpackage

// File: rtl/can_sync_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty.
module can_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/can_wr_channel_buf.sv
// Buffered host write channel: mask check, error capture, FIFO queueing
// and one-hot issue to the register file.
module can_wr_channel_buf
    import can_mcif_pkg::*;
#(
    parameter int                  DATA_W     = CAN_DATA_W,
    parameter int                  ADDR_W     = CAN_ADDR_W,
    parameter int                  DEPTH      = 4,
    parameter logic [2**ADDR_W-1:0] VALID_MASK = CAN_WR_MASK_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_bus_data,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic                       i_reg_stall,
    output logic [2**ADDR_W-1:0]       o_wr_sel,
    output logic [DATA_W-1:0]          o_reg_w_bus,
    output logic [DATA_W/8-1:0]        o_reg_be,
    output logic                       o_wr_err,
    output logic                       o_err_flag,
    output logic [ADDR_W-1:0]          o_err_addr,
    input  logic                       i_err_clr,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int BE_W  = DATA_W / 8;
    localparam int ENT_W = can_entry_w(ADDR_W, DATA_W);
    localparam int SEL_W = 2 ** ADDR_W;

    logic              full;
    logic              empty;
    logic              accept;
    logic              mapped;
    logic              push;
    logic              pop;
    logic              err_hit;
    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  head_ent;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [BE_W-1:0]   head_be;

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              err_q, err_d;
    logic              flag_q, flag_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    assign o_wr_ready = !full;
    assign accept     = i_wr_valid && o_wr_ready;
    assign mapped     = VALID_MASK[i_addr];
    assign push       = accept && mapped && (|i_be);
    assign err_hit    = accept && !mapped;
    assign pop        = !empty && !i_reg_stall;
    assign push_ent   = {i_addr, i_bus_data, i_be};

    assign head_addr = head_ent[ENT_W-1 -: ADDR_W];
    assign head_data = head_ent[BE_W +: DATA_W];
    assign head_be   = head_ent[BE_W-1:0];

    can_sync_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (push_ent),
        .i_pop   (pop),
        .o_data  (head_ent),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_level)
    );

    always_comb begin
        sel_d = '0;
        bus_d = bus_q;
        be_d  = be_q;
        if (pop) begin
            sel_d[head_addr] = 1'b1;
            bus_d            = head_data;
            be_d             = head_be;
        end
    end

    // A clear coinciding with a new error still leaves the flag set and
    // re-arms the capture so the new address is kept.
    always_comb begin
        err_d      = err_hit;
        flag_d     = flag_q;
        err_addr_d = err_addr_q;
        if (i_err_clr) begin
            flag_d = 1'b0;
        end
        if (err_hit) begin
            flag_d = 1'b1;
            if (!flag_q || i_err_clr) begin
                err_addr_d = i_addr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sel_q      <= '0;
            bus_q      <= '0;
            be_q       <= '0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
            err_addr_q <= '0;
        end else begin
            sel_q      <= sel_d;
            bus_q      <= bus_d;
            be_q       <= be_d;
            err_q      <= err_d;
            flag_q     <= flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign o_wr_sel    = sel_q;
    assign o_reg_w_bus = bus_q;
    assign o_reg_be    = be_q;
    assign o_wr_err    = err_q;
    assign o_err_flag  = flag_q;
    assign o_err_addr  = err_addr_q;

endmodule
